// File: rtl/btn_pulse_gen.sv
// Button front end: five independent channels, each a 2-flop synchroniser,
// a debounce counter and a registered rising-edge press pulse. Debounced
// levels are exported as btn_level = {mode, paris, ny, uk, korea}.

module btn_pulse_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after CNT_MAX+1 consecutive
  // disagreeing samples; any agreeing sample restarts qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= s2;
        pulse <= s2;               // press only; release gives no pulse
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_paris,
  input  logic       btn_ny,
  input  logic       btn_uk,
  input  logic       btn_korea,
  output logic       mode_toggle_p,
  output logic       paris_p,
  output logic       ny_p,
  output logic       uk_p,
  output logic       korea_p,
  output logic [4:0] btn_level
);
  localparam int NUM_BTN = 5;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] pulse;

  assign raw = {btn_mode, btn_paris, btn_ny, btn_uk, btn_korea};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_pulse_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .level(btn_level[i]),
      .pulse(pulse[i])
    );
  end

  assign mode_toggle_p = pulse[4];
  assign paris_p       = pulse[3];
  assign ny_p          = pulse[2];
  assign uk_p          = pulse[1];
  assign korea_p       = pulse[0];
endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen with DEBOUNCE_CYCLES=4, CNT_W=3: a vector table,
// hand-written corner sequences and a random phase, all checked every cycle
// against a sliding-window reference model.

module tb_btn_pulse_gen;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  logic       mode_toggle_p, paris_p, ny_p, uk_p, korea_p;
  logic [4:0] btn_level;
  logic [4:0] pv;

  int checks = 0;
  int errors = 0;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_mode     (btn[4]),
    .btn_paris    (btn[3]),
    .btn_ny       (btn[2]),
    .btn_uk       (btn[1]),
    .btn_korea    (btn[0]),
    .mode_toggle_p(mode_toggle_p),
    .paris_p      (paris_p),
    .ny_p         (ny_p),
    .uk_p         (uk_p),
    .korea_p      (korea_p),
    .btn_level    (btn_level)
  );

  always #5 clk = ~clk;

  assign pv = {mode_toggle_p, paris_p, ny_p, uk_p, korea_p};

  // Reference model: a level is accepted once the last DC synchronised
  // samples all disagree with the currently accepted level.
  logic [4:0] rq[$];
  logic [4:0] sq[$];
  logic [4:0] m_level, m_pulse;

  task automatic model_reset();
    rq.delete(); rq.push_back(5'b0); rq.push_back(5'b0);
    sq.delete();
    m_level = '0;
    m_pulse = '0;
  endtask

  task automatic model_edge();
    bit all_diff;
    rq.push_back(btn);
    sq.push_back(rq[rq.size()-3]);
    while (rq.size() > 3) void'(rq.pop_front());
    while (sq.size() > DC) void'(sq.pop_front());
    m_pulse = '0;
    if (sq.size() == DC) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++)
          if (sq[j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = ~m_level[b];
          m_pulse[b] = m_level[b];
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock edge; model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("model", {pv, btn_level}, {m_pulse, m_level});
  endtask

  task automatic idle(input int n);
    btn = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [4:0] btn;
    logic [4:0] p;
    logic [4:0] lvl;
  } vec_t;
  vec_t tbl[$];

  initial begin
    // Vector table: clean paris press/release, then mode glitches.
    for (int k = 0; k < 32; k++)
      tbl.push_back('{(k < 20) ? 5'b01000 : 5'b00000,
                      (k == 5) ? 5'b01000 : 5'b00000,
                      (k >= 5 && k < 25) ? 5'b01000 : 5'b00000});
    for (int k = 0; k < 25; k++)
      tbl.push_back('{(k == 0 || (k >= 11 && k < 14)) ? 5'b10000 : 5'b00000,
                      5'b00000, 5'b00000});

    rst_n = 1'b0;
    btn   = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_state", {pv, btn_level}, 10'b0);
    end
    rst_n = 1'b1;
    idle(4);

    foreach (tbl[i]) begin
      btn = tbl[i].btn;
      step();
      chk($sformatf("tbl[%0d]", i), {pv, btn_level}, {tbl[i].p, tbl[i].lvl});
    end
    idle(12);

    // Bounce on ny: high 3, low 1, then held; the only pulse follows the last rise.
    for (int k = 0; k < 20; k++) begin
      btn = (k < 3 || k >= 4) ? 5'b00100 : 5'b00000;
      step();
      chk("bounce_ny_p", {5'b0, pv}, {5'b0, (k == 9) ? 5'b00100 : 5'b00000});
    end
    idle(12);

    // Release on uk: wait for the level, then drop and time the fall.
    btn = 5'b00010;
    for (int k = 0; k < 12 && !btn_level[1]; k++) step();
    chk("uk_level_up", {9'b0, btn_level[1]}, 10'd1);
    btn = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("uk_release", {8'b0, uk_p, btn_level[1]}, {8'b0, 1'b0, (k < 5)});
    end
    idle(6);

    // Simultaneous korea + mode press.
    for (int k = 0; k < 10; k++) begin
      btn = 5'b10001;
      step();
      chk("simul_p", {5'b0, pv}, {5'b0, (k == 5) ? 5'b10001 : 5'b00000});
    end
    idle(12);

    // Reset mid-count with paris held; held button re-qualifies after reset.
    btn = 5'b01000;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    model_reset();
    #1 chk("mid_reset_async", {pv, btn_level}, 10'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mid_reset_hold", {pv, btn_level}, 10'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_reset_p", {5'b0, pv}, {5'b0, (k == 5) ? 5'b01000 : 5'b00000});
    end
    idle(12);

    // Random phase: each button toggles with probability 1/6 per cycle.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
      step();
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
